// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin merge of per-source result FIFOs onto one writeback port (optional counters: WB_ARB_STATS_EN)
module wb_port_arbiter #(
  parameter int unsigned NR_SRC        = 3,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_SRC-1:0]                    src_valid_i,
  output logic [NR_SRC-1:0]                    src_ready_o,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0] src_trans_id_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]          src_data_i,
  input  logic [NR_SRC-1:0]                    src_ex_valid_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]          src_ex_cause_i,
  output logic                                 wt_valid_o,
  output logic [TRANS_ID_BITS-1:0]             trans_id_o,
  output logic [XLEN-1:0]                      wbdata_o,
  output logic                                 ex_valid_o,
  output logic [XLEN-1:0]                      ex_cause_o,
  output logic [31:0]                          stat_wb_cnt_o,
  output logic [31:0]                          stat_stall_cnt_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(NR_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SRC - 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    logic                     ex_valid;
    logic [XLEN-1:0]          ex_cause;
  } entry_t;

  logic [NR_SRC-1:0]  push;
  logic [NR_SRC-1:0]  pop;
  logic [NR_SRC-1:0]  not_empty;
  entry_t [NR_SRC-1:0] heads;

  logic [IDX_W-1:0] rr_ptr;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;

  for (genvar i = 0; i < NR_SRC; i++) begin : g_fifo
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Ready depends only on the registered count, so a full FIFO refuses even when popping.
    assign src_ready_o[i] = (count != CNT_W'(FIFO_DEPTH));
    assign not_empty[i]   = (count != '0);
    assign push[i]        = src_valid_i[i] & src_ready_o[i] & ~flush_i;
    assign heads[i]       = mem[rd_ptr];

    // Payload storage; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
      if (push[i]) begin
        mem[wr_ptr] <= '{trans_id: src_trans_id_i[i],
                         data:     src_data_i[i],
                         ex_valid: src_ex_valid_i[i],
                         ex_cause: src_ex_cause_i[i]};
      end
    end

    // Pointer and occupancy bookkeeping; flush discards everything buffered.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[i])  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Round-robin search for the first non-empty FIFO starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NR_SRC; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NR_SRC);
      if (!grant_valid && not_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (flush_i) grant_valid = 1'b0;
  end

  assign pop = grant_valid ? (NR_SRC'(1) << grant_idx) : '0;

  // Registered writeback stage; fields hold when idle, flush only kills valid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      wt_valid_o <= 1'b0;
      trans_id_o <= '0;
      wbdata_o   <= '0;
      ex_valid_o <= 1'b0;
      ex_cause_o <= '0;
    end else if (flush_i) begin
      rr_ptr     <= '0;
      wt_valid_o <= 1'b0;
    end else begin
      wt_valid_o <= grant_valid;
      if (grant_valid) begin
        trans_id_o <= heads[grant_idx].trans_id;
        wbdata_o   <= heads[grant_idx].data;
        ex_valid_o <= heads[grant_idx].ex_valid;
        ex_cause_o <= heads[grant_idx].ex_cause;
        rr_ptr     <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] wb_cnt_q;
  logic [31:0] stall_cnt_q;

  // Free-running wrapping counters; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_valid) wb_cnt_q <= wb_cnt_q + 32'd1;
      if (|(src_valid_i & ~src_ready_o)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_wb_cnt_o    = wb_cnt_q;
  assign stat_stall_cnt_o = stall_cnt_q;
`else
  assign stat_wb_cnt_o    = '0;
  assign stat_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed checks of wb_port_arbiter against a queue model
module tb_wb_port_arbiter;

  localparam int NR = 3;
  localparam int D  = 2;
  localparam int TB = 3;
  localparam int XL = 64;
`ifdef WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic                    flush;
  logic [NR-1:0]           sv;
  logic [NR-1:0]           sr;
  logic [NR-1:0][TB-1:0]   sid;
  logic [NR-1:0][XL-1:0]   sdata;
  logic [NR-1:0]           sexv;
  logic [NR-1:0][XL-1:0]   scause;
  logic                    wt_valid;
  logic [TB-1:0]           trans_id;
  logic [XL-1:0]           wbdata;
  logic                    ex_valid;
  logic [XL-1:0]           ex_cause;
  logic [31:0]             st_wb;
  logic [31:0]             st_stall;

  wb_port_arbiter #(.NR_SRC(NR), .FIFO_DEPTH(D), .TRANS_ID_BITS(TB), .XLEN(XL)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .src_valid_i(sv), .src_ready_o(sr), .src_trans_id_i(sid), .src_data_i(sdata),
    .src_ex_valid_i(sexv), .src_ex_cause_i(scause),
    .wt_valid_o(wt_valid), .trans_id_o(trans_id), .wbdata_o(wbdata),
    .ex_valid_o(ex_valid), .ex_cause_o(ex_cause),
    .stat_wb_cnt_o(st_wb), .stat_stall_cnt_o(st_stall)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [TB-1:0] id;
    logic [XL-1:0] data;
    logic          exv;
    logic [XL-1:0] cause;
  } ent_t;

  ent_t        mq [NR][$];
  int          m_rr = 0;
  bit          m_valid = 1'b0;
  ent_t        m_out = '0;
  int unsigned m_wb = 0;
  int unsigned m_stall = 0;
  int          m_g;
  int          m_idx;
  bit          m_stall_any;
  bit [NR-1:0] m_acc;
  logic [NR-1:0] cmp_rdy;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) mq[i].delete();
      m_rr = 0; m_valid = 1'b0; m_out = '0; m_wb = 0; m_stall = 0;
    end else begin
      m_stall_any = 1'b0;
      m_acc = '0;
      for (int i = 0; i < NR; i++) begin
        if (sv[i] && mq[i].size() >= D) m_stall_any = 1'b1;
        m_acc[i] = sv[i] && (mq[i].size() < D) && !flush;
      end
      if (m_stall_any) m_stall++;
      if (flush) begin
        for (int i = 0; i < NR; i++) mq[i].delete();
        m_rr = 0; m_valid = 1'b0;
      end else begin
        m_g = -1;
        for (int k = 0; k < NR; k++) begin
          m_idx = (m_rr + k) % NR;
          if (m_g < 0 && mq[m_idx].size() > 0) m_g = m_idx;
        end
        if (m_g >= 0) begin
          m_out = mq[m_g].pop_front();
          m_valid = 1'b1;
          m_rr = (m_g + 1) % NR;
          m_wb++;
        end else begin
          m_valid = 1'b0;
        end
        for (int i = 0; i < NR; i++)
          if (m_acc[i]) mq[i].push_back('{id: sid[i], data: sdata[i], exv: sexv[i], cause: scause[i]});
      end
    end
  end

  // Compare process: every output against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NR; i++) cmp_rdy[i] = (mq[i].size() != D);
      chk("ready",    64'(sr),       64'(cmp_rdy));
      chk("wt_valid", 64'(wt_valid), 64'(m_valid));
      chk("trans_id", 64'(trans_id), 64'(m_out.id));
      chk("wbdata",   wbdata,        m_out.data);
      chk("ex_valid", 64'(ex_valid), 64'(m_out.exv));
      chk("ex_cause", ex_cause,      m_out.cause);
      chk("stat_wb",    64'(st_wb),    STATS ? 64'(m_wb) : 64'd0);
      chk("stat_stall", 64'(st_stall), STATS ? 64'(m_stall) : 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    sv = '0; sexv = '0; flush = 1'b0;
  endtask

  task automatic set_src(input int i, input int id, input logic [63:0] d, input bit e, input logic [63:0] c);
    sv[i] = 1'b1; sid[i] = TB'(id); sdata[i] = d; sexv[i] = e; scause[i] = c;
  endtask

  int rr_ids [6] = '{1, 2, 3, 4, 5, 6};
  int s0_id;

  initial begin
    rst_n = 1'b0; flush = 1'b0; sv = '0; sid = '0; sdata = '0; sexv = '0; scause = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // Reset state, first cycle after release.
    chk("rst_valid", 64'(wt_valid), 64'd0);
    chk("rst_id",    64'(trans_id), 64'd0);
    chk("rst_data",  wbdata,        64'd0);
    chk("rst_exv",   64'(ex_valid), 64'd0);
    chk("rst_cause", ex_cause,      64'd0);
    chk("rst_ready", 64'(sr),       64'b111);
    chk("rst_swb",   64'(st_wb),    64'd0);
    chk("rst_sst",   64'(st_stall), 64'd0);

    // Single push: visible exactly two cycles later, for one cycle.
    set_src(1, 5, 64'hDEAD, 1'b0, 64'd0);
    tick(); idle();
    chk("lat_t1_valid", 64'(wt_valid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(wt_valid), 64'd1);
    chk("lat_t2_id",    64'(trans_id), 64'd5);
    chk("lat_t2_data",  wbdata,        64'hDEAD);
    tick();
    chk("lat_t3_valid", 64'(wt_valid), 64'd0);

    // Flush brings rr_ptr back to 0.
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl0_ready", 64'(sr), 64'b111);
    chk("fl0_valid", 64'(wt_valid), 64'd0);

    // Two simultaneous bursts served 1..6 in order.
    for (int i = 0; i < 3; i++) set_src(i, i + 1, {$urandom, $urandom}, 1'b0, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) set_src(i, i + 4, {$urandom, $urandom}, 1'b0, 64'd0);
    tick(); idle();
    for (int i = 0; i < 6; i++) begin
      chk("rr_valid", 64'(wt_valid), 64'd1);
      chk("rr_id",    64'(trans_id), 64'(rr_ids[i]));
      tick();
    end
    chk("rr_done", 64'(wt_valid), 64'd0);

    // Exception fields travel with their writeback.
    set_src(2, 7, {$urandom, $urandom}, 1'b1, 64'h2);
    tick(); idle(); tick();
    chk("ex_valid", 64'(wt_valid), 64'd1);
    chk("ex_id",    64'(trans_id), 64'd7);
    chk("ex_exv",   64'(ex_valid), 64'd1);
    chk("ex_cause", ex_cause,      64'h2);
    tick();

    // Backpressure: source 0 always valid, sources 1/2 contribute two each.
    s0_id = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) chk("bp_full_ready0", 64'(sr[0]), 64'd0);
      idle();
      set_src(0, s0_id, {$urandom, $urandom}, 1'b0, 64'd0);
      s0_id = (s0_id + 1) % 8;
      if (c < 2) begin
        set_src(1, 3 + c, {$urandom, $urandom}, 1'b0, 64'd0);
        set_src(2, 5 + c, {$urandom, $urandom}, 1'b0, 64'd0);
      end
      tick();
    end
    idle();
    repeat (10) tick();

    // Flush with four results buffered.
    for (int i = 0; i < 3; i++) set_src(i, i, {$urandom, $urandom}, 1'b0, 64'd0);
    tick(); idle();
    set_src(0, 4, {$urandom, $urandom}, 1'b0, 64'd0);
    set_src(1, 6, {$urandom, $urandom}, 1'b0, 64'd0);
    tick(); idle();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flm_valid", 64'(wt_valid), 64'd0);
    chk("flm_ready", 64'(sr), 64'b111);
    set_src(1, 3, 64'h1234, 1'b0, 64'd0);
    tick(); idle();
    chk("flm_t1_valid", 64'(wt_valid), 64'd0);
    tick();
    chk("flm_t2_valid", 64'(wt_valid), 64'd1);
    chk("flm_t2_id",    64'(trans_id), 64'd3);
    chk("flm_t2_data",  wbdata,        64'h1234);
    tick();

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        sv[i] = (($urandom % 10) < 6);
        sid[i] = TB'($urandom);
        sdata[i] = {$urandom, $urandom};
        sexv[i] = 1'($urandom);
        scause[i] = {$urandom, $urandom};
      end
      flush = (($urandom % 50) == 0);
      rst_n = (($urandom % 300) != 0);
      tick();
    end
    rst_n = 1'b1; idle();
    repeat (8) tick();

    // Counter scenario: six writebacks, three stalled cycles.
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    chk("st_rst_wb",    64'(st_wb),    64'd0);
    chk("st_rst_stall", 64'(st_stall), 64'd0);
    set_src(1, 1, 64'h11, 1'b0, 64'd0); set_src(2, 2, 64'h22, 1'b0, 64'd0);
    tick(); idle();
    set_src(1, 3, 64'h33, 1'b0, 64'd0); set_src(2, 4, 64'h44, 1'b0, 64'd0);
    tick(); idle();
    set_src(0, 5, 64'h55, 1'b0, 64'd0); set_src(2, 6, 64'h66, 1'b0, 64'd0);
    tick(); idle();
    set_src(2, 7, 64'h77, 1'b0, 64'd0);
    tick(); idle();
    set_src(2, 0, 64'h88, 1'b0, 64'd0);
    tick();
    tick(); idle();
    repeat (4) tick();
    chk("st_wb",    64'(st_wb),    STATS ? 64'd6 : 64'd0);
    chk("st_stall", 64'(st_stall), STATS ? 64'd3 : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Producer side of a scoreboard writeback port: merges results from NR_SRC functional units onto one writeback port.
- Drives trans_id, wbdata, exception and valid; the port has no ready, so every asserted valid is consumed that cycle.
- Each source has a small FIFO with valid/ready backpressure. A round-robin arbiter drains the FIFOs into a registered output stage.
- Sits between multi-cycle FUs (mult, FPU, CVXIF result path) and the scoreboard writeback inputs.

Parameters:
- NR_SRC, 3, number of producer FUs (>=2)
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)
- TRANS_ID_BITS, 3, scoreboard transaction-id width
- XLEN, 64, data and exception-cause width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  drop all buffered and in-flight results
- src_valid_i  in  NR_SRC  result valid per source
- src_ready_o  out  NR_SRC  source FIFO can accept
- src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  transaction id per source
- src_data_i  in  NR_SRC x XLEN  result data per source
- src_ex_valid_i  in  NR_SRC  result carries exception
- src_ex_cause_i  in  NR_SRC x XLEN  exception cause
- wt_valid_o  out  1  writeback valid
- trans_id_o  out  TRANS_ID_BITS  writeback transaction id
- wbdata_o  out  XLEN  writeback data
- ex_valid_o  out  1  writeback exception valid
- ex_cause_o  out  XLEN  writeback exception cause
- stat_wb_cnt_o  out  32  total writebacks issued (optional feature)
- stat_stall_cnt_o  out  32  cycles any source had valid & !ready (optional feature)

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset rst_ni is synchronous and active-low; all state updates on the rising edge of clk_i.
  - Reset clears: FIFO counts and pointers, round-robin pointer (to 0), output register, stat counters.
  - Output values after reset: wt_valid_o=0, trans_id_o=0, wbdata_o=0, ex_valid_o=0, ex_cause_o=0, stats=0.
  - src_ready_o is all-ones in the first cycle after reset release.
- Source FIFO:
  - src_ready_o[i] = (count[i] != FIFO_DEPTH). It is a function of registered count only, with no combinational path from src_valid_i.
  - Push when src_valid_i[i] & src_ready_o[i] & !flush_i. The FIFO stores trans_id, data, ex_valid and ex_cause.
  - A full FIFO does not accept a push even if it pops in the same cycle.
  - A non-full FIFO may push and pop in the same cycle; count is unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Arbiter:
  - Combinational over FIFO heads each cycle.
  - Grant goes to the first non-empty FIFO searching from rr_ptr upward, wrapping.
  - On a grant the granted FIFO pops, and rr_ptr becomes (granted+1) mod NR_SRC. With no grant, rr_ptr holds.
  - At most one grant per cycle.
- Output register:
  - Loads the granted head at the clock edge: wt_valid_o=1 next cycle, with its fields.
  - With no grant, wt_valid_o=0; the data fields hold their last values.
- Latency:
  - A push accepted in cycle t into an empty FIFO, uncontested, appears on wt_valid_o in cycle t+2.
  - Sustained throughput is one writeback per cycle.
- Ordering: per-source order is preserved; cross-source order follows round-robin.
- flush_i:
  - In the flush cycle, pushes and grants are suppressed.
  - On the next edge: all counts go to 0, wt_valid_o goes to 0, rr_ptr goes to 0.
  - src_ready_o is all-ones the cycle after the flush.
- Reset mid-operation: identical to flush plus output field clear; buffered results are lost with no writeback.
- flush_i and rst_ni low in the same cycle: reset wins.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined: stat_wb_cnt_o increments on every cycle wt_valid_o is loaded with 1. stat_stall_cnt_o increments on each cycle where any src_valid_i[i] & !src_ready_o[i]. Both counters are 32-bit wrapping, unaffected by flush, and cleared by reset.
- Undefined: both ports tie to 0 and no counter registers exist.

Test Plan:
- Single latency: source 1 pushes trans_id=5, data=0xDEAD at cycle 10 -> wt_valid_o=1, trans_id_o=5, wbdata_o=0xDEAD at cycle 12 only.
- Round-robin: all 3 sources push together (ids 1,2,3) with rr_ptr=0 -> writebacks ids 1,2,3 on consecutive cycles. A second simultaneous burst (ids 4,5,6) is then served in order 4,5,6, because rr_ptr has returned to 0 after the grant to source 2.
- Backpressure: source 0 valid every cycle while sources 1 and 2 hold 2 entries each -> source 0 FIFO fills (2 entries), src_ready_o[0]=0. No push is lost, and ids emerge in push order.
- Exception passthrough: source 2 pushes ex_valid=1, cause=0x2 -> ex_valid_o=1, ex_cause_o=0x2 on the same cycle as its wt_valid_o.
- Flush mid-traffic: 4 results buffered, flush_i pulsed -> no wt_valid_o in the following cycle, all src_ready_o=1, and a new push then emerges with 2-cycle latency.
- Stats (WB_ARB_STATS_EN): 6 writebacks with 3 stalled source-cycles -> stat_wb_cnt_o=6, stat_stall_cnt_o=3. After reset, both read 0.
